// File: rtl/rdcla_wide_seq_if.sv
// rdcla_wide_seq_if
//  Bundles the requester handshake and the external 64-bit adder connection
//  of the wide add sequencer.
//  Requester side : start, op_a, op_b, cin_in -> busy, done, sum, cout
//  Adder side     : add_a, add_b, add_cin -> add_s, add_cout
//  slave  modport : the sequencer itself.
//  master modport : the environment, which is both the requester and the adder.
interface rdcla_wide_seq_if #(
  parameter int W = 256
);
  logic          start;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          cin_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic [63:0]   add_a;
  logic [63:0]   add_b;
  logic          add_cin;
  logic [63:0]   add_s;
  logic          add_cout;

  modport slave (
    input  start, op_a, op_b, cin_in, add_s, add_cout,
    output busy, done, sum, cout, add_a, add_b, add_cin
  );

  modport master (
    output start, op_a, op_b, cin_in, add_s, add_cout,
    input  busy, done, sum, cout, add_a, add_b, add_cin
  );
endinterface

// File: rtl/rdcla_wide_seq.sv
// rdcla_wide_seq
//  Multi-precision add sequencer. Splits NWORDS*64-bit operands into 64-bit
//  words, issues them to an external adder with ADD_LAT cycles of latency,
//  least significant word first, chains the carry from one word into the
//  next and assembles the wide sum.
//  Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - rdcla_wide_seq_if slave: start/op_a/op_b/cin_in in, busy/done/
//          sum/cout out, add_a/add_b/add_cin to the adder, add_s/add_cout
//          back from it.
module rdcla_wide_seq #(
  parameter int NWORDS  = 4,
  parameter int ADD_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  rdcla_wide_seq_if.slave bus
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(ADD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state;
  state_t                  state_n;
  logic [NWORDS-1:0][63:0] a_q;
  logic [NWORDS-1:0][63:0] b_q;
  logic [NWORDS-1:0][63:0] sum_q;
  logic                    carry;
  logic                    cout_q;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic                    last_word;
  logic                    lat_done;

  assign last_word = (idx == LAST_IDX);
  assign lat_done  = (cnt == '0);

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and decoded outputs. The adder operands are only driven
  // while a word is in flight so the adder sees zeros whenever we are idle.
  always_comb begin
    state_n     = state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_n = ISSUE;
      end
      ISSUE: begin
        bus.busy    = 1'b1;
        bus.add_a   = a_q[idx];
        bus.add_b   = b_q[idx];
        bus.add_cin = carry;
        state_n     = WAIT;
      end
      WAIT: begin
        bus.busy    = 1'b1;
        bus.add_a   = a_q[idx];
        bus.add_b   = b_q[idx];
        bus.add_cin = carry;
        if (lat_done) state_n = last_word ? DONE : ISSUE;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_n  = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, latency countdown and result assembly.
  // cout is written together with the last word so that it is already
  // valid in the DONE cycle alongside sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.op_a;
            b_q    <= bus.op_b;
            carry  <= bus.cin_in;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
          end
        end
        ISSUE: begin
          cnt <= CNT_INIT;
        end
        WAIT: begin
          if (lat_done) begin
            sum_q[idx] <= bus.add_s;
            carry      <= bus.add_cout;
            if (last_word) begin
              cout_q <= bus.add_cout;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
